reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Consumes the global internal reset and releases per-domain resets in a fixed order:
//  XADC interface first, then core logic (mux/averaging), then display/UART.
//  Waits for XADC readiness before releasing downstream domains; retries on timeout
//  and flags permanent failure. Sits directly after the PLL-lock reset generator in top.
// PARAMETERS
//  HOLD_CYCLES  16    cycles all resets held after rst release (or retry/restart), >=1
//  ADC_TIMEOUT  1024  max cycles waiting for adc_ready per attempt, >=1
//  STAGE_GAP    8     cycles between successive domain releases, >=1
//  MAX_RETRY    3     timeouts tolerated before FAIL (attempts = MAX_RETRY+1), <=15
// PORTS
//  clk            in   1  system clock
//  rst            in   1  async, active-high reset (from internal reset generator)
//  adc_ready      in   1  XADC interface ready, same clk domain, level
//  soft_restart   in   1  1-cycle pulse: restart sequence from HOLD
//  rst_adc_out    out  1  XADC domain reset, active-high
//  rst_core_out   out  1  core domain reset, active-high
//  rst_disp_out   out  1  display/UART domain reset, active-high
//  seq_done       out  1  all domains released
//  seq_fail       out  1  retries exhausted
//  retry_cnt      out  4  timeouts in current sequence
// BEHAVIOUR
//  - All outputs registered. rst asserted: state=HOLD, cnt=0, rst_*_out=1, seq_done=0,
//    seq_fail=0, retry_cnt=0, immediately (async), from any state.
//  - HOLD: cnt counts 0..HOLD_CYCLES-1; on edge with cnt==HOLD_CYCLES-1: rst_adc_out<=0,
//    cnt<=0, ->WAIT_ADC. rst_adc_out falls on the HOLD_CYCLES-th edge after entry.
//  - WAIT_ADC: adc_ready==1 sampled -> cnt<=0, ->GAP_CORE. Else cnt==ADC_TIMEOUT-1 -> timeout.
//    ready on the final timeout cycle wins (proceeds, no timeout).
//  - Timeout: retry_cnt<MAX_RETRY -> retry_cnt+1, rst_adc_out<=1, cnt<=0, ->HOLD;
//    else ->FAIL, seq_fail<=1, rst_adc_out<=1 (all resets held).
//  - GAP_CORE: cnt 0..STAGE_GAP-1; at STAGE_GAP-1: rst_core_out<=0, cnt<=0, ->GAP_DISP.
//  - GAP_DISP: same count; at STAGE_GAP-1: rst_disp_out<=0, seq_done<=1, ->RUN.
//  - adc_ready ignored outside WAIT_ADC (except optional feature in RUN).
//  - RUN, FAIL: terminal; outputs hold until rst or soft_restart.
//  - soft_restart (any state incl. HOLD): next edge all rst_*_out<=1, seq_done<=0,
//    seq_fail<=0, retry_cnt<=0, cnt<=0, ->HOLD. Overrides same-cycle transitions.
//  - Invariant: release order adc->core->disp; a later domain never out of reset while an
//    earlier one is in reset.
//  - cnt width $clog2 of max(HOLD_CYCLES, ADC_TIMEOUT, STAGE_GAP); no wrap reachable.
// CONFIGURATION
//  RESEQ_ON_READY_LOSS_EN defined: in RUN, adc_ready==0 sampled on 2 consecutive edges ->
//   behaves as soft_restart on the second edge (retry_cnt cleared). 1-cycle drop ignored.
//  Undefined: adc_ready ignored in RUN; no loss counter synthesized.
// TESTING (bench params HOLD_CYCLES=4, ADC_TIMEOUT=8, STAGE_GAP=2, MAX_RETRY=2)
//  1. rst release, adc_ready=1 -> rst_adc_out falls edge 4, rst_core_out edge 7,
//     rst_disp_out + seq_done edge 9 (edges counted from first after release).
//  2. adc_ready=0 forever -> retry_cnt 1 at edge 12, 2 at edge 24; FAIL at edge 36:
//     seq_fail=1, all three resets=1, retry_cnt=2.
//  3. adc_ready rises on 8th WAIT_ADC cycle -> proceeds to GAP_CORE, retry_cnt=0.
//  4. rst pulsed mid GAP_DISP -> rst_*_out=1, seq_done=0 before next edge; clean re-sequence.
//  5. soft_restart pulse in FAIL -> seq_fail=0, retry_cnt=0, HOLD; adc_ready=1 -> test-1 timing.
//  6. In RUN, adc_ready low 1 cycle -> no change; low 2 cycles -> with RESEQ_ON_READY_LOSS_EN
//     all resets reassert, seq_done=0; without macro, no change.

Source files
------------

// File: rtl/reset_sequencer.sv
// Releases per-domain resets in order (XADC -> core -> display/UART) once the XADC reports ready.
// Optional feature: define RESEQ_ON_READY_LOSS_EN to restart the sequence when adc_ready drops in RUN.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int ADC_TIMEOUT = 1024,
    parameter int STAGE_GAP   = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adc_ready,
    input  logic       soft_restart,
    output logic       rst_adc_out,
    output logic       rst_core_out,
    output logic       rst_disp_out,
    output logic       seq_done,
    output logic       seq_fail,
    output logic [3:0] retry_cnt
);

    localparam int MAX_HT  = (HOLD_CYCLES > ADC_TIMEOUT) ? HOLD_CYCLES : ADC_TIMEOUT;
    localparam int MAX_CNT = (MAX_HT > STAGE_GAP) ? MAX_HT : STAGE_GAP;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ADC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_ADC,
        S_GAP_CORE,
        S_GAP_DISP,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_adc_d, rst_core_d, rst_disp_d;
    logic             done_d, fail_d;
    logic [3:0]       retry_d;
    logic             loss_trig;
    logic             restart;

`ifdef RESEQ_ON_READY_LOSS_EN
    // Remembers a low adc_ready sample in RUN so a second consecutive one triggers a restart.
    logic loss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_q <= 1'b0;
        end else begin
            loss_q <= (state_q == S_RUN) && !adc_ready && !soft_restart && !loss_trig;
        end
    end

    assign loss_trig = (state_q == S_RUN) && !adc_ready && loss_q;
`else
    assign loss_trig = 1'b0;
`endif

    assign restart = soft_restart || loss_trig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            rst_adc_out  <= 1'b1;
            rst_core_out <= 1'b1;
            rst_disp_out <= 1'b1;
            seq_done     <= 1'b0;
            seq_fail     <= 1'b0;
            retry_cnt    <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_adc_out  <= rst_adc_d;
            rst_core_out <= rst_core_d;
            rst_disp_out <= rst_disp_d;
            seq_done     <= done_d;
            seq_fail     <= fail_d;
            retry_cnt    <= retry_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_adc_d  = rst_adc_out;
        rst_core_d = rst_core_out;
        rst_disp_d = rst_disp_out;
        done_d     = seq_done;
        fail_d     = seq_fail;
        retry_d    = retry_cnt;

        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    rst_adc_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_WAIT_ADC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_ADC: begin
                // Ready takes priority over a timeout landing on the same cycle.
                if (adc_ready) begin
                    cnt_d   = '0;
                    state_d = S_GAP_CORE;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d     = '0;
                    rst_adc_d = 1'b1;
                    if (retry_cnt < RETRY_MAX) begin
                        retry_d = retry_cnt + 4'd1;
                        state_d = S_HOLD;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP_CORE: begin
                if (cnt_q == GAP_LAST) begin
                    rst_core_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_GAP_DISP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP_DISP: begin
                if (cnt_q == GAP_LAST) begin
                    rst_disp_d = 1'b0;
                    done_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN, S_FAIL: begin
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase

        // A restart request overrides whatever the current state decided this cycle.
        if (restart) begin
            state_d    = S_HOLD;
            cnt_d      = '0;
            rst_adc_d  = 1'b1;
            rst_core_d = 1'b1;
            rst_disp_d = 1'b1;
            done_d     = 1'b0;
            fail_d     = 1'b0;
            retry_d    = 4'd0;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing checks plus randomized stimulus against an
// edge-counting reference model (honours RESEQ_ON_READY_LOSS_EN when defined).
module tb_reset_sequencer;

    localparam int H = 4;
    localparam int T = 8;
    localparam int G = 2;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       adc_ready;
    logic       soft_restart;
    logic       rst_adc_out;
    logic       rst_core_out;
    logic       rst_disp_out;
    logic       seq_done;
    logic       seq_fail;
    logic [3:0] retry_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model: m_mode 0 = sequencing, 1 = run, 2 = fail; m_k = edges since the attempt began;
    // m_rel = edge at which ready was seen (0 = not yet).
    int m_mode, m_k, m_rel, m_retry, m_low;

    reset_sequencer #(
        .HOLD_CYCLES (H),
        .ADC_TIMEOUT (T),
        .STAGE_GAP   (G),
        .MAX_RETRY   (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_ready    (adc_ready),
        .soft_restart (soft_restart),
        .rst_adc_out  (rst_adc_out),
        .rst_core_out (rst_core_out),
        .rst_disp_out (rst_disp_out),
        .seq_done     (seq_done),
        .seq_fail     (seq_fail),
        .retry_cnt    (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] outs();
        return {rst_adc_out, rst_core_out, rst_disp_out, seq_done, seq_fail, retry_cnt};
    endfunction

    task automatic m_reset();
        m_mode  = 0;
        m_k     = 0;
        m_rel   = 0;
        m_retry = 0;
        m_low   = 0;
    endtask

    task automatic m_edge(input logic rdy, input logic sr);
        bit restart;
        restart = sr;
`ifdef RESEQ_ON_READY_LOSS_EN
        if (m_mode == 1 && !rdy) begin
            m_low++;
            if (m_low >= 2) restart = 1'b1;
        end else begin
            m_low = 0;
        end
`endif
        if (restart) begin
            m_reset();
        end else if (m_mode == 0) begin
            m_k++;
            if (m_rel == 0 && m_k > H) begin
                if (rdy) begin
                    m_rel = m_k;
                end else if (m_k == H + T) begin
                    if (m_retry < R) begin
                        m_retry++;
                        m_k = 0;
                    end else begin
                        m_mode = 2;
                    end
                end
            end else if (m_rel != 0 && m_k == m_rel + 2 * G) begin
                m_mode = 1;
            end
        end
    endtask

    function automatic logic [8:0] m_out();
        logic a, c, d;
        a = (m_mode == 2) || (m_mode == 0 && m_k < H);
        c = (m_mode == 2) || (m_mode == 0 && !(m_rel != 0 && m_k >= m_rel + G));
        d = (m_mode != 1);
        return {a, c, d, m_mode == 1, m_mode == 2, 4'(m_retry)};
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge(adc_ready, soft_restart);
        #1;
        chk("model", outs(), m_out());
    endtask

    // Called just after a tick: asserts rst mid-cycle, checks the async effect, releases.
    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1;
        m_reset();
        chk("async_rst", outs(), 9'h1C0);
        #1 rst = 1'b0;
    endtask

    // Expects test-1 timing over the next 10 edges with adc_ready held high.
    task automatic run_t1(input string pfx);
        adc_ready = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            case (e)
                3: chk({pfx, "_adc_e3"},  9'(rst_adc_out), 9'd1);
                4: chk({pfx, "_adc_e4"},  9'(rst_adc_out), 9'd0);
                6: chk({pfx, "_core_e6"}, 9'(rst_core_out), 9'd1);
                7: chk({pfx, "_core_e7"}, 9'(rst_core_out), 9'd0);
                8: chk({pfx, "_disp_e8"}, 9'({rst_disp_out, seq_done}), 9'b10);
                9: chk({pfx, "_disp_e9"}, 9'({rst_disp_out, seq_done}), 9'b01);
                default: ;
            endcase
        end
    endtask

    initial begin
        int p;
        rst          = 1'b1;
        adc_ready    = 1'b0;
        soft_restart = 1'b0;
        m_reset();
        #12;
        chk("reset_state", outs(), 9'h1C0);
        rst = 1'b0;

        // Normal release timing
        run_t1("t1");

        // Async reset in the middle of GAP_DISP, then clean re-sequence
        pulse_rst();
        adc_ready = 1'b1;
        for (int e = 1; e <= 8; e++) tick();
        pulse_rst();
        run_t1("t4");

        // adc_ready never arrives: two retries then FAIL
        pulse_rst();
        adc_ready = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            case (e)
                11: chk("t2_retry_e11", 9'(retry_cnt), 9'd0);
                12: chk("t2_retry_e12", 9'(retry_cnt), 9'd1);
                24: chk("t2_retry_e24", 9'(retry_cnt), 9'd2);
                35: chk("t2_fail_e35",  9'(seq_fail), 9'd0);
                36: chk("t2_fail_e36",  outs(), 9'b111_0_1_0010);
                40: chk("t2_fail_hold", outs(), 9'b111_0_1_0010);
                default: ;
            endcase
        end

        // soft_restart out of FAIL
        soft_restart = 1'b1;
        tick();
        soft_restart = 1'b0;
        chk("t5_restart", outs(), 9'h1C0);
        run_t1("t5");

        // Ready arrives on the final timeout cycle
        pulse_rst();
        adc_ready = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            adc_ready = (e >= 12);
            tick();
            if (e == 12) chk("t3_no_timeout", 9'({retry_cnt, rst_adc_out, rst_core_out}), 9'b0000_0_1);
            if (e == 14) chk("t3_core_rel", 9'(rst_core_out), 9'd0);
            if (e == 16) chk("t3_done", 9'(seq_done), 9'd1);
        end

        // Ready loss in RUN
        adc_ready = 1'b0;
        tick();
        adc_ready = 1'b1;
        tick();
        chk("t6_one_drop", 9'({seq_done, rst_adc_out}), 9'b10);
        adc_ready = 1'b0;
        tick();
        tick();
`ifdef RESEQ_ON_READY_LOSS_EN
        chk("t6_two_drop", outs(), 9'h1C0);
`else
        chk("t6_two_drop", 9'({seq_done, rst_adc_out, rst_disp_out}), 9'b100);
`endif
        adc_ready = 1'b1;

        // Randomized traffic
        p = 100;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(3))
                    0: p = 0;
                    1: p = 50;
                    2: p = 97;
                    default: p = 100;
                endcase
            end
            adc_ready    = ($urandom_range(99) < p);
            soft_restart = ($urandom_range(299) == 0);
            tick();
            soft_restart = 1'b0;
            if ($urandom_range(499) == 0) pulse_rst();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
